regfile_access_arbiter: RTL and testbench
=========================================

// Module: regfile_access_arbiter
// PURPOSE
//  Shares the 32x32 register file's single write port and first read port between two requesters:
//  A = core writeback/operand path, B = debug host.
//  Sits between the multi-cycle core/debug unit and the register file.
//  Also runs a clear sequence that zeroes x1..x31 when the debug host requests it.
//  One access per cycle. Writes to x0 are suppressed.
// PARAMETERS
//  DATA_W        32  register width
//  ADDR_W        5   register index width (32 entries)
//  STARVE_LIMIT  4   consecutive B-losing cycles before B is forced a grant (1..15)
// PORTS
//  CLK              in   1       clock, all state on rising edge
//  RESET_N          in   1       asynchronous, active-low reset
//  a_req / b_req    in   1       access request; held stable until matching gnt
//  a_we / b_we      in   1       1 = write, 0 = read
//  a_addr / b_addr  in   ADDR_W  register index
//  a_wdata/b_wdata  in   DATA_W  write data
//  a_gnt / b_gnt    out  1       combinational; access performed this cycle
//  a_rvalid/b_rvalid out 1       registered; read data valid, 1 cycle after a read gnt
//  a_rdata / b_rdata out DATA_W  registered read data
//  b_clr_req        in   1       request clear of x1..x31; held until b_clr_done
//  b_clr_done       out  1       registered 1-cycle pulse at clear completion
//  busy             out  1       1 while in CLEAR state
//  rf_ReadRegister1 out  ADDR_W  to register file read port 1
//  rf_ReadData1     in   DATA_W  from register file (combinational read)
//  rf_WriteEnable   out  1       to register file
//  rf_WriteRegister out  ADDR_W  to register file
//  rf_WriteData     out  DATA_W  to register file
// BEHAVIOUR
//  Reset (RESET_N=0, async):
//   - state=IDLE; starve_cnt=0; clr_idx=0.
//   - All gnt/rvalid/b_clr_done/busy/rf_WriteEnable = 0; rdata = 0; rf_* address/data = 0.
//   - Reset mid-CLEAR aborts the sweep. No done pulse; registers already cleared stay cleared.
//  FSM states: IDLE, CLEAR.
//  IDLE arbitration, per cycle:
//   - b_clr_req=1 -> no grants this cycle; next state CLEAR, clr_idx=1.
//   - Else if only one req: grant it.
//   - Else if both: A wins, unless starve_cnt==STARVE_LIMIT, then B wins.
//  starve_cnt:
//   - +1 when b_req && !b_gnt in IDLE (saturates at STARVE_LIMIT).
//   - Cleared when b_gnt=1 or b_req=0.
//  Granted write: rf_WriteEnable = (addr!=0), rf_WriteRegister=addr, rf_WriteData=wdata.
//   - Commits at the same edge; gnt still asserted for x0.
//  Granted read:
//   - rf_ReadRegister1=addr; rdata<=rf_ReadData1 at that edge; rvalid=1 next cycle only.
//   - Read of x0 returns 0 regardless of rf_ReadData1.
//  Read and write of the same register in the same cycle cannot occur (one access per cycle).
//   - Read after write in a later cycle returns the new value.
//  rdata holds its last value when rvalid=0. rvalid of a requester is never asserted for writes.
//  CLEAR:
//   - busy=1; no gnt.
//   - Each cycle: rf_WriteEnable=1, rf_WriteRegister=clr_idx, rf_WriteData=0; clr_idx+1.
//   - After the write of index 31 (31 cycles total): b_clr_done pulses, state->IDLE, clr_idx=0.
//   - starve_cnt frozen during CLEAR.
//   - b_clr_req still high on the IDLE return cycle is treated as a new request.
//     Host must drop it on seeing done.
//  Idle defaults (no grant): rf_WriteEnable=0; rf_ReadRegister1=0.
// STRUCTURE
//  Shared package: ADDR_W/DATA_W constants and state encoding (IDLE=0, CLEAR=1).
//   - Register-file width constants are reused by datapath and debug unit.
//  Single module; arbiter priority logic kept inline. No sub-module needed.
// TESTING
//  1. Reset: RESET_N=0 mid-stream -> all outputs 0 immediately, state IDLE.
//  2. A write x5=0xDEADBEEF then A read x5 -> a_gnt both cycles.
//     - Read: a_rvalid next cycle with a_rdata=0xDEADBEEF.
//  3. A write x0=0x1234 -> a_gnt=1, rf_WriteEnable=0. Read x0 -> a_rdata=0.
//  4. a_req,b_req held high continuously, STARVE_LIMIT=4 -> A granted 4 cycles, B on the 5th.
//     - Pattern repeats; B never waits >4 cycles.
//  5. Fill x1..x31 with index value, pulse b_clr_req -> busy for 31 cycles, b_clr_done once.
//     - Reads of x1..x31 return 0.
//  6. Assert RESET_N=0 at clr_idx=10 -> no b_clr_done.
//     - After release: x1..x9 read 0 (a reset register file also reads 0).
//     - Arbiter returns to IDLE and grants normally.

Source files
------------

// File: rtl/regfile_access_arbiter_pkg.sv
// Shared register-file constants and arbiter state encoding.
// Width constants are also used by the datapath and the debug unit.
package regfile_access_arbiter_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned ADDR_W = 5;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_CLEAR = 1'b1
   } arb_state_e;

endpackage

// File: rtl/regfile_access_arbiter.sv
// Shares the register-file write port and read port 1 between the core (A)
// and the debug host (B), and sweeps x1..x31 to zero on a debug clear request.
module regfile_access_arbiter
   import regfile_access_arbiter_pkg::*;
#(
   parameter int unsigned STARVE_LIMIT = 4
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_gnt,
   output logic              a_rvalid,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_gnt,
   output logic              b_rvalid,
   output logic [DATA_W-1:0] b_rdata,
   input  logic              b_clr_req,
   output logic              b_clr_done,
   output logic              busy,
   output logic [ADDR_W-1:0] rf_ReadRegister1,
   input  logic [DATA_W-1:0] rf_ReadData1,
   output logic              rf_WriteEnable,
   output logic [ADDR_W-1:0] rf_WriteRegister,
   output logic [DATA_W-1:0] rf_WriteData
);

   localparam logic [3:0]        LP_LIMIT = 4'(STARVE_LIMIT);
   localparam logic [ADDR_W-1:0] LP_LAST  = '1;
   localparam logic [ADDR_W-1:0] LP_FIRST = ADDR_W'(1);

   arb_state_e        r_state;
   arb_state_e        w_state_nxt;
   logic [3:0]        r_starve_cnt;
   logic [ADDR_W-1:0] r_clr_idx;
   logic              r_clr_done;
   logic              r_a_rvalid;
   logic              r_b_rvalid;
   logic [DATA_W-1:0] r_a_rdata;
   logic [DATA_W-1:0] r_b_rdata;
   logic              w_sel_we;
   logic [ADDR_W-1:0] w_sel_addr;
   logic [DATA_W-1:0] w_sel_wdata;

   always_comb begin
      w_state_nxt      = r_state;
      a_gnt            = 1'b0;
      b_gnt            = 1'b0;
      busy             = 1'b0;
      rf_WriteEnable   = 1'b0;
      rf_WriteRegister = '0;
      rf_WriteData     = '0;
      rf_ReadRegister1 = '0;
      w_sel_we         = 1'b0;
      w_sel_addr       = '0;
      w_sel_wdata      = '0;
      // Grants are combinational, so they are gated to zero during reset.
      if (RESET_N) begin
         unique case (r_state)
            ST_IDLE: begin
               if (b_clr_req) begin
                  w_state_nxt = ST_CLEAR;
               end else if (a_req && b_req) begin
                  if (r_starve_cnt == LP_LIMIT) b_gnt = 1'b1;
                  else                          a_gnt = 1'b1;
               end else begin
                  a_gnt = a_req;
                  b_gnt = b_req;
               end
            end
            ST_CLEAR: begin
               busy             = 1'b1;
               rf_WriteEnable   = 1'b1;
               rf_WriteRegister = r_clr_idx;
               if (r_clr_idx == LP_LAST) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
         endcase
         if (a_gnt || b_gnt) begin
            w_sel_we    = a_gnt ? a_we    : b_we;
            w_sel_addr  = a_gnt ? a_addr  : b_addr;
            w_sel_wdata = a_gnt ? a_wdata : b_wdata;
            if (w_sel_we) begin
               rf_WriteEnable   = (w_sel_addr != '0);
               rf_WriteRegister = w_sel_addr;
               rf_WriteData     = w_sel_wdata;
            end else begin
               rf_ReadRegister1 = w_sel_addr;
            end
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         r_state      <= ST_IDLE;
         r_starve_cnt <= '0;
         r_clr_idx    <= '0;
         r_clr_done   <= 1'b0;
         r_a_rvalid   <= 1'b0;
         r_b_rvalid   <= 1'b0;
         r_a_rdata    <= '0;
         r_b_rdata    <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_clr_done <= (r_state == ST_CLEAR) && (r_clr_idx == LP_LAST);
         if (r_state == ST_IDLE) begin
            r_clr_idx <= b_clr_req ? LP_FIRST : '0;
            if (!b_req || b_gnt)
               r_starve_cnt <= '0;
            else if (r_starve_cnt != LP_LIMIT)
               r_starve_cnt <= r_starve_cnt + 4'd1;
         end else begin
            // Wraps 31 -> 0 on the final sweep write.
            r_clr_idx <= r_clr_idx + LP_FIRST;
         end
         r_a_rvalid <= a_gnt && !a_we;
         r_b_rvalid <= b_gnt && !b_we;
         if (a_gnt && !a_we)
            r_a_rdata <= (a_addr == '0) ? '0 : rf_ReadData1;
         if (b_gnt && !b_we)
            r_b_rdata <= (b_addr == '0) ? '0 : rf_ReadData1;
      end
   end

   assign a_rvalid   = r_a_rvalid;
   assign b_rvalid   = r_b_rvalid;
   assign a_rdata    = r_a_rdata;
   assign b_rdata    = r_b_rdata;
   assign b_clr_done = r_clr_done;

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// Randomised self-checking bench for regfile_access_arbiter with a
// behavioural register-file/arbitration model.
module tb_regfile_access_arbiter;
   import regfile_access_arbiter_pkg::*;

   localparam int LIM = 4;

   logic              CLK = 1'b0;
   logic              RESET_N;
   logic              a_req, a_we, b_req, b_we, b_clr_req;
   logic [ADDR_W-1:0] a_addr, b_addr;
   logic [DATA_W-1:0] a_wdata, b_wdata;
   logic              a_gnt, b_gnt, a_rvalid, b_rvalid, b_clr_done, busy;
   logic [DATA_W-1:0] a_rdata, b_rdata;
   logic [ADDR_W-1:0] rf_ReadRegister1, rf_WriteRegister;
   logic [DATA_W-1:0] rf_ReadData1, rf_WriteData;
   logic              rf_WriteEnable;

   logic [DATA_W-1:0] rf_mem [32];
   logic [DATA_W-1:0] m_rf   [32];
   int total = 0;
   int bad   = 0;

   regfile_access_arbiter #(.STARVE_LIMIT(LIM)) dut (
      .CLK(CLK), .RESET_N(RESET_N),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
      .b_clr_req(b_clr_req), .b_clr_done(b_clr_done), .busy(busy),
      .rf_ReadRegister1(rf_ReadRegister1), .rf_ReadData1(rf_ReadData1),
      .rf_WriteEnable(rf_WriteEnable), .rf_WriteRegister(rf_WriteRegister),
      .rf_WriteData(rf_WriteData)
   );

   always #5 CLK = ~CLK;

   assign rf_ReadData1 = rf_mem[rf_ReadRegister1];
   always @(posedge CLK) if (rf_WriteEnable) rf_mem[rf_WriteRegister] <= rf_WriteData;

   task automatic test_reset();
      @(negedge CLK);
      a_req = 1; a_we = 1; a_addr = 5'd3; a_wdata = 32'h55;
      b_req = 1; b_we = 0; b_addr = 5'd4;
      #1;
      total++;
      if (a_gnt !== 1'b1) begin
         bad++; $display("FAIL reset_pre_gnt act=%b exp=1", a_gnt);
      end
      RESET_N = 0;
      #1;
      total++;
      if ({a_gnt, b_gnt, a_rvalid, b_rvalid, b_clr_done, busy, rf_WriteEnable} !== 7'b0) begin
         bad++;
         $display("FAIL reset_ctl act=%b exp=0",
                  {a_gnt, b_gnt, a_rvalid, b_rvalid, b_clr_done, busy, rf_WriteEnable});
      end
      total++;
      if ({rf_WriteRegister, rf_WriteData, rf_ReadRegister1, a_rdata, b_rdata} !== '0) begin
         bad++;
         $display("FAIL reset_data act=%h/%h/%h/%h/%h exp=0", rf_WriteRegister,
                  rf_WriteData, rf_ReadRegister1, a_rdata, b_rdata);
      end
      a_req = 0; b_req = 0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1;
      #1;
      total++;
      if ({a_gnt, b_gnt, busy, rf_WriteEnable, a_rvalid} !== 5'b0) begin
         bad++; $display("FAIL reset_release act=%b exp=0",
                         {a_gnt, b_gnt, busy, rf_WriteEnable, a_rvalid});
      end
   endtask

   task automatic test_write_read();
      @(negedge CLK);
      a_req = 1; a_we = 1; a_addr = 5'd5; a_wdata = 32'hDEADBEEF;
      #1;
      total++;
      if ({a_gnt, rf_WriteEnable, rf_WriteRegister, rf_WriteData} !== {2'b11, 5'd5, 32'hDEADBEEF}) begin
         bad++; $display("FAIL wr_x5 act=%b%b/%h/%h exp=11/05/deadbeef",
                         a_gnt, rf_WriteEnable, rf_WriteRegister, rf_WriteData);
      end
      m_rf[5] = 32'hDEADBEEF;
      @(posedge CLK);
      @(negedge CLK);
      a_we = 0;
      #1;
      total++;
      if (a_gnt !== 1'b1 || rf_ReadRegister1 !== 5'd5 || rf_WriteEnable !== 1'b0) begin
         bad++; $display("FAIL rd_x5_gnt act=%b/%h/%b exp=1/05/0",
                         a_gnt, rf_ReadRegister1, rf_WriteEnable);
      end
      @(posedge CLK);
      @(negedge CLK);
      a_req = 0;
      total++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL rd_x5_data act=%b/%h exp=1/deadbeef", a_rvalid, a_rdata);
      end
      @(negedge CLK);
      total++;
      if (a_rvalid !== 1'b0 || a_rdata !== 32'hDEADBEEF) begin
         bad++; $display("FAIL rd_hold act=%b/%h exp=0/deadbeef", a_rvalid, a_rdata);
      end
   endtask

   task automatic test_x0();
      @(negedge CLK);
      a_req = 1; a_we = 1; a_addr = 5'd0; a_wdata = 32'h1234;
      #1;
      total++;
      if (a_gnt !== 1'b1 || rf_WriteEnable !== 1'b0) begin
         bad++; $display("FAIL wr_x0 act=%b/%b exp=1/0", a_gnt, rf_WriteEnable);
      end
      @(posedge CLK);
      @(negedge CLK);
      a_we = 0;
      #1;
      total++;
      if (a_gnt !== 1'b1) begin
         bad++; $display("FAIL rd_x0_gnt act=%b exp=1", a_gnt);
      end
      @(posedge CLK);
      @(negedge CLK);
      a_req = 0;
      total++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'h0) begin
         bad++; $display("FAIL rd_x0_data act=%b/%h exp=1/0", a_rvalid, a_rdata);
      end
      total++;
      if (a_rvalid === 1'b1 && rf_mem[0] !== 32'hBAD0BAD0) begin
         bad++; $display("FAIL x0_store act=%h exp=bad0bad0", rf_mem[0]);
      end
   endtask

   task automatic test_starve();
      int wait_b = 0;
      int max_wait = 0;
      logic ea, eb;
      for (int k = 0; k < 20; k++) begin
         @(negedge CLK);
         a_req = 1; a_we = 1; a_addr = 5'($urandom_range(1, 31)); a_wdata = $urandom;
         b_req = 1; b_we = 1; b_addr = 5'($urandom_range(1, 31)); b_wdata = $urandom;
         #1;
         eb = (k % (LIM + 1)) == LIM;
         ea = !eb;
         total++;
         if (a_gnt !== ea || b_gnt !== eb) begin
            bad++; $display("FAIL starve_k%0d act=%b%b exp=%b%b", k, a_gnt, b_gnt, ea, eb);
         end
         if (ea) m_rf[a_addr] = a_wdata;
         else    m_rf[b_addr] = b_wdata;
         if (b_gnt === 1'b1) wait_b = 0;
         else wait_b++;
         if (wait_b > max_wait) max_wait = wait_b;
         @(posedge CLK);
      end
      @(negedge CLK);
      a_req = 0; b_req = 0;
      total++;
      if (max_wait > LIM) begin
         bad++; $display("FAIL starve_max act=%0d exp<=%0d", max_wait, LIM);
      end
      @(negedge CLK);
   endtask

   task automatic test_random();
      logic ea, eb, ag, bg, exp_arv, exp_brv;
      logic [DATA_W-1:0] exp_ard, exp_brd;
      int losses = 0;
      ag = 0; bg = 0; exp_arv = 0; exp_brv = 0;
      exp_ard = '0; exp_brd = '0;
      for (int c = 0; c < 400; c++) begin
         @(negedge CLK);
         total++;
         if (a_rvalid !== exp_arv || (exp_arv && a_rdata !== exp_ard)) begin
            bad++; $display("FAIL rnd_a_rd c%0d act=%b/%h exp=%b/%h",
                            c, a_rvalid, a_rdata, exp_arv, exp_ard);
         end
         total++;
         if (b_rvalid !== exp_brv || (exp_brv && b_rdata !== exp_brd)) begin
            bad++; $display("FAIL rnd_b_rd c%0d act=%b/%h exp=%b/%h",
                            c, b_rvalid, b_rdata, exp_brv, exp_brd);
         end
         if (!a_req || ag) begin
            a_req = 1'($urandom_range(0, 1)); a_we = 1'($urandom_range(0, 1));
            a_addr = 5'($urandom_range(0, 31)); a_wdata = $urandom;
         end
         if (!b_req || bg) begin
            b_req = 1'($urandom_range(0, 1)); b_we = 1'($urandom_range(0, 1));
            b_addr = 5'($urandom_range(0, 31)); b_wdata = $urandom;
         end
         #1;
         ea = a_req && (!b_req || losses < LIM);
         eb = b_req && !ea;
         total++;
         if (a_gnt !== ea || b_gnt !== eb) begin
            bad++; $display("FAIL rnd_gnt c%0d act=%b%b exp=%b%b", c, a_gnt, b_gnt, ea, eb);
         end
         if ((ea && a_we) || (eb && b_we)) begin
            total++;
            if (rf_WriteEnable !== ((ea ? a_addr : b_addr) != 5'd0)) begin
               bad++; $display("FAIL rnd_we c%0d act=%b addr=%0d", c, rf_WriteEnable,
                               ea ? a_addr : b_addr);
            end
         end
         exp_arv = ea && !a_we;
         exp_brv = eb && !b_we;
         if (exp_arv) exp_ard = (a_addr == 0) ? '0 : m_rf[a_addr];
         if (exp_brv) exp_brd = (b_addr == 0) ? '0 : m_rf[b_addr];
         if (ea && a_we && a_addr != 0) m_rf[a_addr] = a_wdata;
         if (eb && b_we && b_addr != 0) m_rf[b_addr] = b_wdata;
         losses = (b_req && !eb) ? ((losses < LIM) ? losses + 1 : LIM) : 0;
         ag = ea; bg = eb;
         @(posedge CLK);
      end
      @(negedge CLK);
      a_req = 0; b_req = 0;
      @(negedge CLK);
   endtask

   task automatic test_clear();
      int nbusy = 0;
      int ndone = 0;
      for (int i = 1; i < 32; i++) begin
         @(negedge CLK);
         a_req = 1; a_we = 1; a_addr = 5'(i); a_wdata = 32'(i);
         m_rf[i] = 32'(i);
         @(posedge CLK);
      end
      @(negedge CLK);
      a_we = 0; a_addr = 5'd7; b_clr_req = 1;
      #1;
      total++;
      if (a_gnt !== 1'b0 || busy !== 1'b0) begin
         bad++; $display("FAIL clr_req_cycle act=%b/%b exp=0/0", a_gnt, busy);
      end
      @(posedge CLK);
      for (int c = 0; c < 80 && ndone == 0; c++) begin
         @(negedge CLK);
         if (busy === 1'b1) begin
            nbusy++;
            total++;
            if (rf_WriteEnable !== 1'b1 || rf_WriteRegister !== 5'(nbusy) ||
                rf_WriteData !== 32'h0 || a_gnt !== 1'b0) begin
               bad++; $display("FAIL clr_sweep n%0d act=%b/%0d/%h/%b exp=1/%0d/0/0", nbusy,
                               rf_WriteEnable, rf_WriteRegister, rf_WriteData, a_gnt, nbusy);
            end
         end
         if (b_clr_done === 1'b1) ndone++;
      end
      b_clr_req = 0;
      #1;
      total++;
      if (ndone != 1 || nbusy != 31) begin
         bad++; $display("FAIL clr_count act=busy%0d/done%0d exp=busy31/done1", nbusy, ndone);
      end
      total++;
      if (a_gnt !== 1'b1 || busy !== 1'b0) begin
         bad++; $display("FAIL clr_return act=%b/%b exp=1/0", a_gnt, busy);
      end
      for (int i = 1; i < 32; i++) m_rf[i] = '0;
      @(posedge CLK);
      @(negedge CLK);
      a_req = 0;
      total++;
      if (a_rvalid !== 1'b1 || a_rdata !== 32'h0 || b_clr_done !== 1'b0) begin
         bad++; $display("FAIL clr_after act=%b/%h/%b exp=1/0/0", a_rvalid, a_rdata, b_clr_done);
      end
      for (int i = 1; i <= 32; i++) begin
         @(negedge CLK);
         if (i > 1) begin
            total++;
            if (a_rvalid !== 1'b1 || a_rdata !== m_rf[i-1]) begin
               bad++; $display("FAIL clr_rd_x%0d act=%b/%h exp=1/%h",
                               i - 1, a_rvalid, a_rdata, m_rf[i-1]);
            end
         end
         a_req = (i < 32); a_we = 0; a_addr = 5'(i);
         @(posedge CLK);
      end
   endtask

   task automatic test_reset_mid_clear();
      int ndone = 0;
      bit found = 0;
      for (int i = 1; i < 32; i++) begin
         @(negedge CLK);
         a_req = 1; a_we = 1; a_addr = 5'(i); a_wdata = 32'(i);
         m_rf[i] = 32'(i);
         @(posedge CLK);
      end
      @(negedge CLK);
      a_req = 0; b_clr_req = 1;
      @(posedge CLK);
      for (int c = 0; c < 60 && !found; c++) begin
         @(negedge CLK);
         if (b_clr_done === 1'b1) ndone++;
         if (busy === 1'b1 && rf_WriteRegister === 5'd10) found = 1;
      end
      total++;
      if (!found) begin
         bad++; $display("FAIL rmc_reach act=%0d exp=1", found);
      end
      RESET_N = 0; b_clr_req = 0;
      #1;
      total++;
      if (busy !== 1'b0 || rf_WriteEnable !== 1'b0) begin
         bad++; $display("FAIL rmc_abort act=%b/%b exp=0/0", busy, rf_WriteEnable);
      end
      for (int i = 1; i < 10; i++) m_rf[i] = '0;
      repeat (2) @(negedge CLK);
      RESET_N = 1;
      for (int c = 0; c < 40; c++) begin
         @(negedge CLK);
         if (b_clr_done === 1'b1 || busy === 1'b1) ndone++;
      end
      total++;
      if (ndone != 0) begin
         bad++; $display("FAIL rmc_no_done act=%0d exp=0", ndone);
      end
      for (int i = 1; i <= 32; i++) begin
         @(negedge CLK);
         if (i > 1) begin
            total++;
            if (a_rvalid !== 1'b1 || a_rdata !== m_rf[i-1]) begin
               bad++; $display("FAIL rmc_rd_x%0d act=%b/%h exp=1/%h",
                               i - 1, a_rvalid, a_rdata, m_rf[i-1]);
            end
         end
         a_req = (i < 32); a_we = 0; a_addr = 5'(i);
         if (i < 32) begin
            #1;
            total++;
            if (a_gnt !== 1'b1) begin
               bad++; $display("FAIL rmc_gnt_x%0d act=%b exp=1", i, a_gnt);
            end
         end
         @(posedge CLK);
      end
   endtask

   initial begin
      RESET_N = 0; b_clr_req = 0;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      for (int i = 0; i < 32; i++) begin
         m_rf[i] = $urandom;
         rf_mem[i] <= m_rf[i];
      end
      rf_mem[0] <= 32'hBAD0BAD0;
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RESET_N = 1;
      test_reset();
      test_write_read();
      test_x0();
      test_starve();
      test_random();
      test_clear();
      test_reset_mid_clear();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
